// File: rtl/exec_flags_stage.sv
// exec_flags_stage: execute-to-writeback register capturing ALU result/dest into wb_* (valid/stall handshake) and ALU status into psr, with cond_true evaluation and carry_out feedback
module exec_flags_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_flag,
  input  logic              alu_low,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              flags_we,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              flush,
  input  logic              psr_load,
  input  logic [4:0]        psr_din,
  input  logic              wb_stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_reg,
  output logic              wb_we,
  output logic [4:0]        psr,
  output logic              carry_out,
  input  logic [3:0]        cond,
  output logic              cond_true
);
  logic        accept;
  logic        we_q;
  logic        c, f, l, n, z;
  logic [15:0] cond_vec;
  assign in_ready  = !wb_valid | !wb_stall;
  assign accept    = in_valid & in_ready & !flush;
  assign wb_we     = wb_valid & we_q;
  assign carry_out = psr[4];
  assign {c, f, l, n, z} = psr;
  assign cond_vec = {1'b0, 1'b1, !n, n, !f, f, n | z, !n & !z,
                     !l, l, l | z, !l & !z, !c, c, !z, z};
  assign cond_true = cond_vec[cond];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_reg   <= '0;
      we_q     <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      wb_data  <= alu_result;
      wb_reg   <= dest_reg;
      we_q     <= reg_we;
    end else if (!wb_stall) begin
      wb_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) psr <= '0;
    else if (psr_load) psr <= psr_din;
    else if (accept && flags_we) psr <= {alu_carry, alu_flag, alu_low, alu_negative, alu_zero};
  end
endmodule

// File: tb/tb_exec_flags_stage.sv
// tb_exec_flags_stage: randomized and directed self-checking bench for exec_flags_stage
module tb_exec_flags_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [15:0] alu_result;
  logic        alu_carry, alu_flag, alu_low, alu_negative, alu_zero;
  logic        flags_we, reg_we, flush, psr_load, wb_stall;
  logic [3:0]  dest_reg;
  logic [4:0]  psr_din;
  logic        wb_valid, wb_we, carry_out, cond_true;
  logic [15:0] wb_data;
  logic [3:0]  wb_reg;
  logic [4:0]  psr;
  logic [3:0]  cond;
  int checks = 0;
  int failures = 0;

  exec_flags_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_flag(alu_flag),
    .alu_low(alu_low), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .flags_we(flags_we), .reg_we(reg_we), .dest_reg(dest_reg), .flush(flush),
    .psr_load(psr_load), .psr_din(psr_din), .wb_stall(wb_stall),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg), .wb_we(wb_we),
    .psr(psr), .carry_out(carry_out), .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [4:0] p, input logic [3:0] cc);
    logic cf, ff, lf, nf, zf;
    {cf, ff, lf, nf, zf} = p;
    case (cc)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return !lf && !zf;
      4'd5:  return lf || zf;
      4'd6:  return lf;
      4'd7:  return !lf;
      4'd8:  return !nf && !zf;
      4'd9:  return nf || zf;
      4'd10: return ff;
      4'd11: return !ff;
      4'd12: return nf;
      4'd13: return !nf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    in_valid = 0; alu_result = 0; alu_carry = 0; alu_flag = 0; alu_low = 0;
    alu_negative = 0; alu_zero = 0; flags_we = 0; reg_we = 0; dest_reg = 0;
    flush = 0; psr_load = 0; psr_din = 0; wb_stall = 0; cond = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (wb_valid !== 0 || psr !== 0 || wb_data !== 0 || wb_reg !== 0 || wb_we !== 0 || carry_out !== 0) begin
      failures++;
      $display("FAIL reset_initial: valid=%b psr=%b data=%h reg=%h we=%b co=%b, required all zero",
               wb_valid, psr, wb_data, wb_reg, wb_we, carry_out);
    end
    idle();
    in_valid = 1; alu_result = 16'hc3c3; reg_we = 1; dest_reg = 4'hb; psr_load = 1; psr_din = 5'b11111;
    step();
    idle();
    checks++;
    if (psr !== 5'b11111 || wb_valid !== 1) begin
      failures++;
      $display("FAIL reset_setup: psr=%b valid=%b, required 11111 1", psr, wb_valid);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if (wb_valid !== 0 || psr !== 0 || wb_data !== 0 || wb_reg !== 0 || wb_we !== 0 || carry_out !== 0) begin
      failures++;
      $display("FAIL reset_async: valid=%b psr=%b data=%h reg=%h we=%b co=%b, required all zero",
               wb_valid, psr, wb_data, wb_reg, wb_we, carry_out);
    end
    #1 reset_n = 1;
    step();
    checks++;
    if (wb_valid !== 0 || psr !== 0) begin
      failures++;
      $display("FAIL reset_after_edge: valid=%b psr=%b, required 0 00000", wb_valid, psr);
    end
  endtask

  task automatic test_flag_capture();
    idle();
    in_valid = 1; alu_result = 16'h0000; alu_carry = 1; alu_zero = 1; flags_we = 1; reg_we = 1; dest_reg = 5;
    step();
    idle();
    checks++;
    if (psr !== 5'b10001 || carry_out !== 1 || wb_valid !== 1 || wb_data !== 0 || wb_reg !== 5 || wb_we !== 1) begin
      failures++;
      $display("FAIL flag_capture: psr=%b co=%b valid=%b data=%h reg=%h we=%b, required 10001 1 1 0000 5 1",
               psr, carry_out, wb_valid, wb_data, wb_reg, wb_we);
    end
    for (int k = 0; k < 3; k++) begin
      logic [3:0] cc;
      logic exp;
      cc = (k == 0) ? 4'd0 : (k == 1) ? 4'd2 : 4'd3;
      exp = (k != 2);
      cond = cc; #1;
      checks++;
      if (cond_true !== exp) begin
        failures++;
        $display("FAIL flag_cond: cond=%0d got=%b required=%b", cc, cond_true, exp);
      end
    end
    idle();
    in_valid = 1; alu_result = 16'h8000; alu_negative = 1; flags_we = 0; reg_we = 0;
    step();
    idle();
    checks++;
    if (psr !== 5'b10001 || wb_valid !== 1 || wb_data !== 16'h8000 || wb_we !== 0) begin
      failures++;
      $display("FAIL flags_we_off: psr=%b valid=%b data=%h we=%b, required 10001 1 8000 0",
               psr, wb_valid, wb_data, wb_we);
    end
  endtask

  task automatic test_conditions();
    for (int v = 0; v < 32; v++) begin
      idle();
      psr_load = 1; psr_din = v[4:0];
      step();
      psr_load = 0;
      checks++;
      if (psr !== v[4:0]) begin
        failures++;
        $display("FAIL cond_psr_load: psr=%b required=%b", psr, v[4:0]);
      end
      for (int c = 0; c < 16; c++) begin
        cond = c[3:0]; #1;
        checks++;
        if (cond_true !== ref_cond(v[4:0], c[3:0])) begin
          failures++;
          $display("FAIL cond_sweep: psr=%b cond=%0d got=%b required=%b",
                   v[4:0], c, cond_true, ref_cond(v[4:0], c[3:0]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    idle();
    in_valid = 1; alu_result = 16'h1234; dest_reg = 3; reg_we = 1;
    step();
    alu_result = 16'h5678; dest_reg = 7; wb_stall = 1;
    #1;
    checks++;
    if (in_ready !== 0) begin
      failures++;
      $display("FAIL bp_ready_low: in_ready=%b required=0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wb_valid !== 1 || wb_data !== 16'h1234 || wb_reg !== 3 || wb_we !== 1 || in_ready !== 0) begin
        failures++;
        $display("FAIL bp_hold: cyc=%0d valid=%b data=%h reg=%h we=%b rdy=%b, required 1 1234 3 1 0",
                 i, wb_valid, wb_data, wb_reg, wb_we, in_ready);
      end
    end
    wb_stall = 0; #1;
    checks++;
    if (in_ready !== 1) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%b required=1", in_ready);
    end
    step();
    in_valid = 0;
    checks++;
    if (wb_valid !== 1 || wb_data !== 16'h5678 || wb_reg !== 7 || wb_we !== 1) begin
      failures++;
      $display("FAIL bp_release_load: valid=%b data=%h reg=%h we=%b, required 1 5678 7 1",
               wb_valid, wb_data, wb_reg, wb_we);
    end
    step();
    checks++;
    if (wb_valid !== 0) begin
      failures++;
      $display("FAIL bp_no_duplicate: valid=%b required=0", wb_valid);
    end
  endtask

  task automatic test_flush();
    idle();
    psr_load = 1; psr_din = 5'b00000;
    step();
    idle();
    in_valid = 1; alu_result = 16'habcd; alu_zero = 1; flags_we = 1; reg_we = 1; flush = 1;
    step();
    checks++;
    if (wb_valid !== 0 || psr !== 5'b00000 || wb_we !== 0) begin
      failures++;
      $display("FAIL flush_kill: valid=%b psr=%b we=%b, required 0 00000 0", wb_valid, psr, wb_we);
    end
    psr_load = 1; psr_din = 5'b01000;
    step();
    idle();
    checks++;
    if (wb_valid !== 0 || psr !== 5'b01000) begin
      failures++;
      $display("FAIL flush_psr_load: valid=%b psr=%b, required 0 01000", wb_valid, psr);
    end
    in_valid = 1; alu_result = 16'h1111; dest_reg = 2;
    step();
    in_valid = 0; wb_stall = 1; flush = 1;
    step();
    idle();
    checks++;
    if (wb_valid !== 0) begin
      failures++;
      $display("FAIL flush_over_stall: valid=%b required=0", wb_valid);
    end
  endtask

  task automatic test_priority();
    idle();
    psr_load = 1; psr_din = 5'b00001;
    in_valid = 1; flags_we = 1; alu_carry = 1; alu_result = 16'hbeef; dest_reg = 9; reg_we = 1;
    step();
    idle();
    checks++;
    if (psr !== 5'b00001 || wb_valid !== 1 || wb_data !== 16'hbeef || wb_reg !== 9 || carry_out !== 0) begin
      failures++;
      $display("FAIL priority: psr=%b valid=%b data=%h reg=%h co=%b, required 00001 1 beef 9 0",
               psr, wb_valid, wb_data, wb_reg, carry_out);
    end
  endtask

  task automatic test_random();
    logic        m_valid, m_we, rdy, acc;
    logic [15:0] m_data;
    logic [3:0]  m_reg;
    logic [4:0]  m_psr;
    idle();
    step();
    m_valid = wb_valid; m_we = wb_we; m_data = wb_data; m_reg = wb_reg; m_psr = psr;
    if (wb_valid) begin
      checks++;
      failures++;
      $display("FAIL random_start: valid=%b required=0", wb_valid);
      m_valid = 0;
    end
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(3) != 0);
      alu_result = 16'($urandom);
      {alu_carry, alu_flag, alu_low, alu_negative, alu_zero} = 5'($urandom);
      flags_we = $urandom_range(1);
      reg_we = $urandom_range(1);
      dest_reg = 4'($urandom);
      flush = ($urandom_range(7) == 0);
      psr_load = ($urandom_range(5) == 0);
      psr_din = 5'($urandom);
      wb_stall = ($urandom_range(2) == 0);
      cond = 4'($urandom);
      #1;
      rdy = !(m_valid && wb_stall);
      acc = in_valid && rdy && !flush;
      checks++;
      if (in_ready !== rdy || cond_true !== ref_cond(m_psr, cond)) begin
        failures++;
        $display("FAIL random_comb: i=%0d in_ready=%b/%b cond_true=%b/%b", i, in_ready, rdy,
                 cond_true, ref_cond(m_psr, cond));
      end
      if (psr_load) m_psr = psr_din;
      else if (acc && flags_we) m_psr = {alu_carry, alu_flag, alu_low, alu_negative, alu_zero};
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_data = alu_result; m_reg = dest_reg; m_we = reg_we;
      end else if (!(m_valid && wb_stall)) m_valid = 0;
      step();
      checks++;
      if (wb_valid !== m_valid || psr !== m_psr || carry_out !== m_psr[4] || wb_we !== (m_valid && m_we) ||
          (m_valid && (wb_data !== m_data || wb_reg !== m_reg))) begin
        failures++;
        $display("FAIL random_state: i=%0d valid=%b/%b psr=%b/%b co=%b we=%b/%b data=%h/%h reg=%h/%h",
                 i, wb_valid, m_valid, psr, m_psr, carry_out, wb_we, m_valid && m_we,
                 wb_data, m_data, wb_reg, m_reg);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 0;
    #12 reset_n = 1;
    test_reset();
    test_flag_capture();
    test_conditions();
    test_backpressure();
    test_flush();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/exec_flags_stage.md
Name: exec_flags_stage

Overview:
- Execute-to-writeback pipeline register that sits directly downstream of the 16-bit ALU.
- Captures the ALU result, destination register index and the five status outputs (Carry, Flag, Low, Negative, Zero) into the architectural processor status register (PSR).
- Evaluates 4-bit branch/jump/set condition codes against the PSR.
- Feeds the registered carry back to the ALU CarryIn for add-with-carry sequences.

Parameters:
- DATA_W, 16, datapath width of the result and writeback bus.
- REG_AW, 4, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU stage holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- alu_result  in  DATA_W  ALU C output
- alu_carry, alu_flag, alu_low, alu_negative, alu_zero  in  1 each  ALU status outputs
- flags_we  in  1  instruction updates the PSR
- reg_we  in  1  instruction writes a register
- dest_reg  in  REG_AW  destination register index
- flush  in  1  kill the instruction being accepted and empty the stage
- psr_load  in  1  software PSR write
- psr_din  in  5  {C,F,L,N,Z} for psr_load
- wb_stall  in  1  register file cannot take writeback
- wb_valid  out  1  writeback slot occupied
- wb_data  out  DATA_W  registered result
- wb_reg  out  REG_AW  registered destination
- wb_we  out  1  wb_valid & registered reg_we
- psr  out  5  {C,F,L,N,Z}
- carry_out  out  1  psr[4], wired to ALU CarryIn
- cond  in  4  condition code
- cond_true  out  1  combinational result of cond evaluated against psr

Behaviour:
- Reset (async, reset_n=0): wb_valid=0, wb_data=0, wb_reg=0, wb_we=0, psr=5'b0, carry_out=0. Outputs hold these values from assertion until the first clock edge after deassertion. Reset mid-transfer discards the slot and the PSR.
- in_ready = !wb_valid | !wb_stall (combinational).
- Accept occurs when in_valid & in_ready & !flush.
  - On accept, the next edge loads wb_data, wb_reg and the reg_we copy, and sets wb_valid=1.
  - Latency is 1 cycle from accept to wb_valid.
- No accept, slot not stalled: wb_valid clears at the edge.
- wb_stall=1 with wb_valid=1: all wb_* outputs hold.
- flush=1: the edge forces wb_valid=0, and the incoming instruction neither loads nor touches the PSR. flush takes priority over stall.
- PSR update priority, highest first:
  1. psr_load: psr<=psr_din, regardless of accept or flush.
  2. Accept with flags_we=1: psr<={alu_carry,alu_flag,alu_low,alu_negative,alu_zero}.
  3. Otherwise psr holds.
- An accept with flags_we=0 leaves the PSR unchanged.
- The PSR is written at the accept edge. The next instruction in the ALU therefore sees the new carry_out and cond_true one cycle later, with no bypass.
- Condition encoding (C=psr[4], F=psr[3], L=psr[2], N=psr[1], Z=psr[0]):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: !L & !Z
  - 5 LS: L | Z
  - 6 LO: L
  - 7 HS: !L
  - 8 GT: !N & !Z
  - 9 LE: N | Z
  - 10 FS: F
  - 11 FC: !F
  - 12 LT: N
  - 13 GE: !N
  - 14 UC: 1
  - 15 NV: 0
- Simultaneous accept and stall-release in the same cycle: the old slot leaves and the new one loads (full throughput, one per cycle).
- Widths: data paths are DATA_W exact, no extension. psr_din bits map 1:1 to psr bits.

Test Plan:
- Reset: pulse reset_n low mid-cycle with psr=5'b11111 and wb_valid=1 -> psr=0, wb_valid=0 immediately, without waiting for a clock edge.
- Flag capture:
  - Accept result 0x0000 with carry=1, zero=1, flags_we=1 -> next cycle psr=5'b10001, carry_out=1, cond 0 (EQ)=1, cond 2 (CS)=1, cond 3 (CC)=0.
  - Then accept with flags_we=0 -> psr unchanged.
- Conditions: psr_load 5'b00100 (L=1) -> cond 6 (LO)=1, 5 (LS)=1, 4 (HI)=0, 7 (HS)=0. psr_load 5'b00010 -> cond 12 (LT)=1, 9 (LE)=1, 8 (GT)=0. Sweep all 16 codes with each of the 32 PSR values against the table.
- Backpressure:
  - Accept 0x1234 to reg 3, then assert wb_stall for 3 cycles with in_valid=1 and 0x5678 waiting -> in_ready=0; wb_data=0x1234, wb_reg=3, wb_we=1 held.
  - Release -> 0x5678 loads next edge, with no drop or duplicate.
- Flush: flush=1 with in_valid=1, flags_we=1, alu_zero=1 -> wb_valid=0 and psr unchanged. Simultaneous psr_load 5'b01000 -> psr=5'b01000.
- Priority: same-cycle psr_load 5'b00001 and accept with flags_we=1 and alu_carry=1 -> psr=5'b00001 and wb_data loads normally.
